// File: rtl/pll_lock_mgr.sv
// ============================================================================
// Module   : pll_lock_mgr
// Brief    : PLL reset/lock sequencer with timeout, retry and sticky fault.
//            Optional lock-loss event counter under PLL_LOCK_MGR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_mgr #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst,
    input  logic       retry_req,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       user_rst,
    output logic       pll_ok,
    output logic       fault,
    output logic       lock_loss,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       retry_nxt;
    logic             lock_loss_nxt;
    logic             lock_meta, lock_s;

    // pll_lock is asynchronous to clk
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        retry_nxt     = retry_cnt;
        lock_loss_nxt = 1'b0;
        if (soft_rst) begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
            retry_nxt = 2'd0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // a lock seen on the timeout cycle still counts as a lock
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_nxt = '0;
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = S_FAULT;
                        end else begin
                            state_nxt = S_RESET;
                            retry_nxt = retry_cnt + 2'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                        retry_nxt = 2'd0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    retry_nxt = 2'd0;
                    if (!lock_s) begin
                        state_nxt     = S_RESET;
                        cnt_nxt       = '0;
                        lock_loss_nxt = 1'b1;
                    end
                end
                S_FAULT: begin
                    if (retry_req) begin
                        state_nxt = S_RESET;
                        cnt_nxt   = '0;
                        retry_nxt = 2'd0;
                    end
                end
                default: begin
                    state_nxt = S_RESET;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // outputs decoded from next state so they move with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET;
            cnt       <= '0;
            retry_cnt <= 2'd0;
            pll_rst   <= 1'b1;
            user_rst  <= 1'b1;
            pll_ok    <= 1'b0;
            fault     <= 1'b0;
            lock_loss <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= (state_nxt == S_RESET) || (state_nxt == S_FAULT);
            user_rst  <= (state_nxt != S_RUN);
            pll_ok    <= (state_nxt == S_RUN);
            fault     <= (state_nxt == S_FAULT);
            lock_loss <= lock_loss_nxt;
        end
    end

`ifdef PLL_LOCK_MGR_CNT_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt <= 8'd0;
        end else if (lock_loss_nxt && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_mgr.sv
// ============================================================================
// Module   : tb_pll_lock_mgr
// Brief    : Scoreboard bench for pll_lock_mgr (per-cycle expected traces).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_mgr;

    localparam int RC = 4;
    localparam int TO = 100;
    localparam int SC = 8;
    localparam int MR = 2;
`ifdef PLL_LOCK_MGR_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       soft_rst  = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_lock  = 1'b0;
    logic       pll_rst, user_rst, pll_ok, fault, lock_loss;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    logic [14:0] obs;
    logic [14:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign obs = {pll_rst, user_rst, pll_ok, fault, lock_loss, retry_cnt, lock_loss_cnt};

    always #5 clk = ~clk;

    pll_lock_mgr #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .MAX_RETRY     (MR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .soft_rst      (soft_rst),
        .retry_req     (retry_req),
        .pll_lock      (pll_lock),
        .pll_rst       (pll_rst),
        .user_rst      (user_rst),
        .pll_ok        (pll_ok),
        .fault         (fault),
        .lock_loss     (lock_loss),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // bit order: pll_rst user_rst pll_ok fault lock_loss retry_cnt[1:0] lock_loss_cnt[7:0]
    function automatic logic [14:0] mk(input bit pr, input bit ur, input bit ok, input bit f,
                                       input bit ll, input int rc, input int llc);
        return {pr, ur, ok, f, ll, 2'(rc), 8'(llc)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        soft_rst  = 1'b0;
        retry_req = 1'b0;
        pll_lock  = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] ev;
        rst = 1'b1; pll_lock = 1'b1; soft_rst = 1'b1; retry_req = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%b exp=%b", i, obs, ev);
            end
        end
        soft_rst = 1'b0; retry_req = 1'b0; pll_lock = 1'b0;
    endtask

    task automatic test_bringup();
        logic [14:0] ev;
        do_reset();
        for (int k = 1; k <= 40; k++) exp_q.push_back(mk(k < 4, k < 31, k >= 31, 0, 0, 0, 0));
        for (int k = 1; k <= 40; k++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL bringup k=%0d got=%b exp=%b", k, obs, ev);
            end
            if (k == 20) pll_lock = 1'b1;
        end
    endtask

    task automatic test_no_lock();
        logic [14:0] ev;
        do_reset();
        // each failed attempt is RC cycles of reset plus TO cycles of waiting
        for (int k = 1; k <= 340; k++) begin
            if (k < 312)
                exp_q.push_back(mk((k % 104) < 4, 1, 0, 0, 0, k / 104, 0));
            else if (k <= 330)
                exp_q.push_back(mk(1, 1, 0, 1, 0, 2, 0));
            else
                exp_q.push_back(mk((k - 331) < 4, 1, 0, 0, 0, 0, 0));
        end
        for (int k = 1; k <= 340; k++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL no_lock k=%0d got=%b exp=%b", k, obs, ev);
            end
            retry_req = (k == 50) || (k == 330);
        end
    endtask

    task automatic test_glitch();
        logic [14:0] ev;
        do_reset();
        for (int k = 1; k <= 135; k++)
            exp_q.push_back(mk((k < 4) || (k >= 104 && k < 108), k < 128, k >= 128, 0, 0,
                               (k >= 104 && k < 128) ? 1 : 0, 0));
        for (int k = 1; k <= 135; k++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL glitch k=%0d got=%b exp=%b", k, obs, ev);
            end
            if (k == 110) pll_lock = 1'b1;
            if (k == 116) pll_lock = 1'b0;
            if (k == 117) pll_lock = 1'b1;
        end
    endtask

    task automatic test_boundary();
        logic [14:0] ev;
        do_reset();
        for (int k = 1; k <= 120; k++) exp_q.push_back(mk(k < 4, k < 112, k >= 112, 0, 0, 0, 0));
        for (int k = 1; k <= 120; k++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL boundary k=%0d got=%b exp=%b", k, obs, ev);
            end
            // synchronized lock lands exactly on the last timeout cycle
            if (k == 101) pll_lock = 1'b1;
        end
    endtask

    task automatic test_lock_loss();
        logic [14:0] ev;
        pll_lock = 1'b0;
        for (int k = 1; k <= 20; k++)
            exp_q.push_back(mk(k >= 3 && k < 7, k >= 3, k < 3, 0, k == 3, 0,
                               (CNT_EN != 0 && k >= 3) ? 1 : 0));
        for (int k = 1; k <= 20; k++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL lock_loss k=%0d got=%b exp=%b", k, obs, ev);
            end
        end
    endtask

    task automatic test_soft_rst_run();
        logic [14:0] ev;
        bit          run;
        pll_lock = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            run = (k >= 11 && k < 21) || (k >= 34);
            exp_q.push_back(mk(k >= 21 && k < 25, !run, run, 0, 0, 0, CNT_EN));
        end
        for (int k = 1; k <= 40; k++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL soft_rst_run k=%0d got=%b exp=%b", k, obs, ev);
            end
            soft_rst = (k == 20);
        end
    endtask

    task automatic test_soft_rst_fault();
        logic [14:0] ev;
        do_reset();
        for (int k = 1; k <= 325; k++) begin
            if (k < 312)
                exp_q.push_back(mk((k % 104) < 4, 1, 0, 0, 0, k / 104, 0));
            else if (k < 316)
                exp_q.push_back(mk(1, 1, 0, 1, 0, 2, 0));
            else
                exp_q.push_back(mk(k < 320, 1, 0, 0, 0, 0, 0));
        end
        for (int k = 1; k <= 325; k++) begin
            cyc();
            ev = exp_q.pop_front();
            n_tests++;
            if (obs !== ev) begin
                n_fail++;
                $display("FAIL soft_rst_fault k=%0d got=%b exp=%b", k, obs, ev);
            end
            soft_rst = (k == 315);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_no_lock();
        test_glitch();
        test_boundary();
        test_lock_loss();
        test_soft_rst_run();
        test_soft_rst_fault();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
